// File: rtl/mdr_block.sv
// Memory data register bridging a 32-bit processor bus and an 8-bit data memory port.
// Latency 1 cycle for all strobes; no backpressure, strobes are accepted every cycle once armed.
module mdr_block (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        w_en,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] data_in,
  input  logic [7:0]  DRAM_in,
  output logic [31:0] data_out,
  output logic [7:0]  DRAM_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mdr_q, mdr_d;
  logic [7:0]  dram_out_q, dram_out_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mdr_q      <= 32'h0;
      dram_out_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      mdr_q      <= mdr_d;
      dram_out_q <= dram_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mdr_d      = mdr_q;
    dram_out_d = dram_out_q;
    case (state_q)
      IDLE: begin
        // Strobes are dropped here, even on the arming cycle.
        if (enable) state_d = ACTIVE;
      end
      ACTIVE: begin
        state_d = ACTIVE;
        if (w_en) begin
          mdr_d = data_in;
        end else if (read_en) begin
          mdr_d = {24'h0, DRAM_in};
        end
        // Uses the pre-edge register value, so a same-cycle load does not leak through.
        if (write_en) dram_out_d = mdr_q[7:0];
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out = mdr_q;
  assign DRAM_out = dram_out_q;

endmodule

// File: tb/tb_mdr_block.sv
// Randomized and directed bench for mdr_block against a rule-level reference model.
module tb_mdr_block;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        w_en;
  logic        read_en;
  logic        write_en;
  logic [31:0] data_in;
  logic [7:0]  DRAM_in;
  logic [31:0] data_out;
  logic [7:0]  DRAM_out;

  int checks = 0;
  int errors = 0;

  // Reference model: armed flag, register contents, memory-side byte.
  bit          m_armed;
  logic [31:0] m_mdr;
  logic [7:0]  m_dram;

  mdr_block dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .w_en     (w_en),
    .read_en  (read_en),
    .write_en (write_en),
    .data_in  (data_in),
    .DRAM_in  (DRAM_in),
    .data_out (data_out),
    .DRAM_out (DRAM_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic e, input logic w, input logic r, input logic wr,
                       input logic [31:0] d, input logic [7:0] dr);
    enable   = e;
    w_en     = w;
    read_en  = r;
    write_en = wr;
    data_in  = d;
    DRAM_in  = dr;
  endtask

  task automatic model_reset();
    m_armed = 1'b0;
    m_mdr   = 32'h0;
    m_dram  = 8'h0;
  endtask

  // One clock: model applies the rules to the values present at the edge, then we move to the falling edge.
  task automatic step();
    logic [7:0]  old_low;
    @(posedge clk);
    if (rst_n) begin
      if (!m_armed) begin
        if (enable) m_armed = 1'b1;
      end else begin
        old_low = m_mdr[7:0];
        if (w_en)         m_mdr = data_in;
        else if (read_en) m_mdr = {24'h0, DRAM_in};
        if (write_en)     m_dram = old_low;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 1, 32'hFFFF_FFFF, 8'hFF);
    model_reset();
    #2;
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want %h", data_out, 32'h0); end
    checks++;
    if (DRAM_out !== 8'h0) begin errors++; $display("FAIL reset_dram_out got %h want %h", DRAM_out, 8'h0); end
    step();
    step();
    checks++;
    if (data_out !== 32'h0 || DRAM_out !== 8'h0) begin
      errors++; $display("FAIL reset_inputs_ignored got %h/%h want 0/0", data_out, DRAM_out);
    end
    drive(0, 0, 0, 0, 32'h0, 8'h0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_ignore();
    drive(0, 1, 0, 1, 32'h1234_5678, 8'h00);
    step();
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL idle_w_en got %h want %h", data_out, 32'h0); end
    // Arming cycle: strobe must still be dropped.
    drive(1, 1, 0, 0, 32'h1234_5678, 8'h00);
    step();
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL arm_cycle_w_en got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_basic_flow();
    drive(0, 1, 0, 0, 32'hA5A5_A5A5, 8'h00);
    step();
    checks++;
    if (data_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL w_en_load got %h want %h", data_out, 32'hA5A5_A5A5); end
    drive(0, 0, 1, 0, 32'h0, 8'd150);
    step();
    checks++;
    if (data_out !== 32'h0000_0096) begin errors++; $display("FAIL read_en_zext got %h want %h", data_out, 32'h96); end
    checks++;
    if (DRAM_out !== 8'h0) begin errors++; $display("FAIL dram_out_hold got %h want %h", DRAM_out, 8'h0); end
    drive(0, 0, 0, 1, 32'h0, 8'd150);
    step();
    checks++;
    if (DRAM_out !== 8'h96) begin errors++; $display("FAIL write_en_out got %h want %h", DRAM_out, 8'h96); end
    drive(0, 0, 0, 0, 32'h0, 8'hFF);
    step();
    step();
    checks++;
    if (data_out !== 32'h96 || DRAM_out !== 8'h96) begin
      errors++; $display("FAIL no_strobe_hold got %h/%h want 00000096/96", data_out, DRAM_out);
    end
  endtask

  task automatic test_priority_and_overlap();
    drive(1, 1, 1, 0, 32'hDEAD_BEEF, 8'h11);
    step();
    checks++;
    if (data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL w_en_priority got %h want %h", data_out, 32'hDEADBEEF); end
    drive(0, 1, 0, 0, 32'h0000_00AA, 8'h00);
    step();
    drive(0, 1, 0, 1, 32'h0000_0055, 8'h00);
    step();
    checks++;
    if (DRAM_out !== 8'hAA) begin errors++; $display("FAIL same_edge_dram_out got %h want %h", DRAM_out, 8'hAA); end
    checks++;
    if (data_out !== 32'h55) begin errors++; $display("FAIL same_edge_data_out got %h want %h", data_out, 32'h55); end
    drive(0, 0, 1, 1, 32'h0, 8'h3C);
    step();
    checks++;
    if (DRAM_out !== 8'h55 || data_out !== 32'h3C) begin
      errors++; $display("FAIL read_write_same_edge got %h/%h want 0000003c/55", data_out, DRAM_out);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0, 1, 32'hCAFE_F00D, 8'h00);
    step();
    drive(0, 0, 0, 0, 32'h0, 8'h00);
    // Pulse low between edges; outputs must clear before the next clock.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (data_out !== 32'h0 || DRAM_out !== 8'h0) begin
      errors++; $display("FAIL async_reset_clear got %h/%h want 0/0", data_out, DRAM_out);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0000_0077, 8'h00);
    step();
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL post_reset_needs_enable got %h want %h", data_out, 32'h0); end
    drive(1, 0, 0, 0, 32'h0, 8'h00);
    step();
    drive(0, 1, 0, 0, 32'h0000_0077, 8'h00);
    step();
    checks++;
    if (data_out !== 32'h77) begin errors++; $display("FAIL post_reset_rearm got %h want %h", data_out, 32'h77); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), $urandom, 8'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
      end
      step();
      checks++;
      if (data_out !== m_mdr || DRAM_out !== m_dram) begin
        errors++;
        $display("FAIL random_cycle_%0d got %h/%h want %h/%h", i, data_out, DRAM_out, m_mdr, m_dram);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic_flow();
    test_priority_and_overlap();
    test_async_reset();
    // Restart from reset so the random phase also exercises arming.
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_block.md
MDR_BLOCK -- requirements
Module: mdr_block

Interface
REQ-001 SHALL have ports: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: enable  input  1  arms the block, moving it from IDLE to ACTIVE.
REQ-004 SHALL have ports: w_en  input  1  load data_in into the 32-bit data register.
REQ-005 SHALL have ports: read_en  input  1  capture DRAM_in into the data register.
REQ-006 SHALL have ports: write_en  input  1  drive the register low byte onto DRAM_out.
REQ-007 SHALL have ports: data_in  input  32  processor-side write data.
REQ-008 SHALL have ports: DRAM_in  input  8  byte read from data memory.
REQ-009 SHALL have ports: data_out  output  32  current data-register contents.
REQ-010 SHALL have ports: DRAM_out  output  8  registered byte to data memory.
REQ-011 SHALL have no parameters; widths are fixed at 32 (bus) and 8 (memory).

Function
REQ-012 SHALL contain one 32-bit register MDR, one 8-bit register DRAM_out and a 2-bit state register.
REQ-013 State encoding SHALL be IDLE=2'd0 and ACTIVE=2'd2; codes 1 and 3 SHALL return to IDLE on the next edge.
REQ-014 In IDLE with enable=1 the state SHALL become ACTIVE at the next rising edge; enable=0 holds IDLE.
REQ-015 In IDLE, w_en, read_en and write_en SHALL be ignored, including on the cycle enable is sampled.
REQ-016 ACTIVE SHALL persist until reset; enable is a don't-care in ACTIVE.
REQ-017 In ACTIVE with w_en=1: MDR <= data_in at the next edge (1-cycle latency).
REQ-018 In ACTIVE with read_en=1 and w_en=0: MDR <= {24'h0, DRAM_in} (zero-extended) at the next edge.
REQ-019 w_en and read_en both 1: w_en SHALL win; DRAM_in is discarded.
REQ-020 In ACTIVE with write_en=1: DRAM_out <= MDR[7:0] at the next edge, using MDR value before that edge's update.
REQ-021 write_en is independent of w_en/read_en; it SHALL operate on the same edge as either.
REQ-022 With no strobe asserted, MDR and DRAM_out SHALL hold.
REQ-023 data_out SHALL equal MDR continuously, with no extra pipeline stage.
REQ-024 DRAM_out SHALL change only on a write_en edge or on reset.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, MDR=32'h0 and DRAM_out=8'h0.
REQ-026 While rst_n=0 all inputs SHALL be ignored.
REQ-027 Deasserting rst_n mid-operation SHALL resume from IDLE; enable is required again.

Verification
REQ-028 Scenario: enable=1 one cycle, w_en=1 with data_in=32'hA5A5A5A5 -> data_out=32'hA5A5A5A5 after that edge.
REQ-029 Scenario: continuing REQ-028, read_en=1 with DRAM_in=8'd150, then write_en=1 -> data_out=32'h00000096 and DRAM_out=8'h96; a later DRAM_in change to 8'hFF with no strobe leaves both unchanged.
REQ-030 Scenario: in IDLE (enable never set), w_en=1 with data_in=32'h12345678 -> data_out stays 32'h0.
REQ-031 Scenario: in ACTIVE, w_en=1 and read_en=1 with data_in=32'hDEADBEEF and DRAM_in=8'h11 -> data_out=32'hDEADBEEF.
REQ-032 Scenario: in ACTIVE with MDR=32'h000000AA, w_en=1 (data_in=32'h55) and write_en=1 on the same edge -> DRAM_out=8'hAA, data_out=32'h00000055.
REQ-033 Scenario: rst_n pulsed low between clock edges while ACTIVE and MDR nonzero -> data_out=0 and DRAM_out=0 immediately; w_en is ignored until enable is reasserted.
